// File: rtl/pattern_dac_burst.sv
// Burst pattern serialiser driving a DAC word from latched high/low levels.
// Repeats an explicit-length bit pattern with optional inter-pattern gaps and start/stop/abort control.
module pattern_dac_burst #(
  parameter int PAT_WIDTH   = 16,
  parameter int DAC_WIDTH   = 14,
  parameter int CNT_WIDTH   = 16,
  parameter int BURST_WIDTH = 8,
  parameter int LEN_WIDTH   = $clog2(PAT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   abort,
  input  logic [PAT_WIDTH-1:0]   pat,
  input  logic [LEN_WIDTH-1:0]   pat_len,
  input  logic [CNT_WIDTH-1:0]   bit_cycles,
  input  logic [CNT_WIDTH-1:0]   gap_cycles,
  input  logic [BURST_WIDTH-1:0] burst_num,
  input  logic [DAC_WIDTH-1:0]   lvl_hi,
  input  logic [DAC_WIDTH-1:0]   lvl_lo,
  input  logic [DAC_WIDTH-1:0]   lvl_idle,
  output logic [DAC_WIDTH-1:0]   dac_data,
  output logic                   pat_out,
  output logic                   busy,
  output logic                   done,
  output logic [BURST_WIDTH-1:0] burst_cnt
);

  // state    | meaning
  // S_IDLE   | waiting for start, DAC at live idle level
  // S_ACTIVE | serialising pattern bits
  // S_GAP    | inter-pattern gap, pat_out low
  // S_DONE   | one-cycle end-of-run pulse
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP, S_DONE} state_t;

  state_t state, state_nx;

  logic [PAT_WIDTH-1:0]   pat_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [CNT_WIDTH-1:0]   bit_cycles_q;
  logic [CNT_WIDTH-1:0]   gap_q;
  logic [BURST_WIDTH-1:0] burst_num_q;
  logic [DAC_WIDTH-1:0]   lvl_hi_q;
  logic [DAC_WIDTH-1:0]   lvl_lo_q;

  logic [LEN_WIDTH-1:0]   bit_idx, bit_idx_nx;
  logic [CNT_WIDTH-1:0]   bit_cnt, bit_cnt_nx;
  logic [CNT_WIDTH-1:0]   gap_cnt, gap_cnt_nx;
  logic [BURST_WIDTH-1:0] burst_cnt_nx;
  logic                   stop_pend, stop_pend_nx;
  logic                   pat_out_nx;
  logic                   load_cfg;

  logic [LEN_WIDTH-1:0]   idx_inc;
  logic [BURST_WIDTH-1:0] burst_inc;
  logic                   last_pat;

  assign idx_inc   = bit_idx + LEN_WIDTH'(1);
  assign burst_inc = burst_cnt + BURST_WIDTH'(1);
  assign last_pat  = (burst_num_q != '0) && (burst_inc == burst_num_q);

  assign busy = (state == S_ACTIVE) || (state == S_GAP);
  assign done = (state == S_DONE);

  always_comb begin
    state_nx     = state;
    pat_out_nx   = pat_out;
    bit_idx_nx   = bit_idx;
    bit_cnt_nx   = bit_cnt;
    gap_cnt_nx   = gap_cnt;
    burst_cnt_nx = burst_cnt;
    stop_pend_nx = stop_pend;
    load_cfg     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          load_cfg     = 1'b1;
          state_nx     = S_ACTIVE;
          bit_idx_nx   = '0;
          bit_cnt_nx   = bit_cycles;
          pat_out_nx   = pat[0];
          burst_cnt_nx = '0;
          stop_pend_nx = 1'b0;
        end
      end

      S_ACTIVE: begin
        if (stop) stop_pend_nx = 1'b1;
        if (abort) begin
          state_nx   = S_DONE;
          pat_out_nx = 1'b0;
        end else if (bit_cnt != '0) begin
          bit_cnt_nx = bit_cnt - CNT_WIDTH'(1);
        end else if (bit_idx != len_q) begin
          bit_idx_nx = idx_inc;
          bit_cnt_nx = bit_cycles_q;
          pat_out_nx = pat_q[idx_inc];
        end else begin
          // Pattern boundary: a stop raised on this very cycle still ends the run here.
          burst_cnt_nx = burst_inc;
          if (last_pat || stop_pend || stop) begin
            state_nx   = S_DONE;
            pat_out_nx = 1'b0;
          end else if (gap_q == '0) begin
            bit_idx_nx = '0;
            bit_cnt_nx = bit_cycles_q;
            pat_out_nx = pat_q[0];
          end else begin
            state_nx   = S_GAP;
            gap_cnt_nx = gap_q - CNT_WIDTH'(1);
            pat_out_nx = 1'b0;
          end
        end
      end

      S_GAP: begin
        if (stop) stop_pend_nx = 1'b1;
        if (abort || stop_pend) begin
          state_nx   = S_DONE;
          pat_out_nx = 1'b0;
        end else if (gap_cnt == '0) begin
          state_nx   = S_ACTIVE;
          bit_idx_nx = '0;
          bit_cnt_nx = bit_cycles_q;
          pat_out_nx = pat_q[0];
        end else begin
          gap_cnt_nx = gap_cnt - CNT_WIDTH'(1);
        end
      end

      S_DONE: begin
        state_nx   = S_IDLE;
        pat_out_nx = 1'b0;
      end

      default: begin
        state_nx   = S_IDLE;
        pat_out_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pat_out   <= 1'b0;
      bit_idx   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      burst_cnt <= '0;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_nx;
      pat_out   <= pat_out_nx;
      bit_idx   <= bit_idx_nx;
      bit_cnt   <= bit_cnt_nx;
      gap_cnt   <= gap_cnt_nx;
      burst_cnt <= burst_cnt_nx;
      stop_pend <= stop_pend_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q        <= '0;
      len_q        <= '0;
      bit_cycles_q <= '0;
      gap_q        <= '0;
      burst_num_q  <= '0;
      lvl_hi_q     <= '0;
      lvl_lo_q     <= '0;
    end else if (load_cfg) begin
      pat_q        <= pat;
      len_q        <= pat_len;
      bit_cycles_q <= bit_cycles;
      gap_q        <= gap_cycles;
      burst_num_q  <= burst_num;
      lvl_hi_q     <= lvl_hi;
      lvl_lo_q     <= lvl_lo;
    end
  end

  // DAC word follows the registered state/pat_out, so it trails pat_out by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_data <= '0;
    end else begin
      case (state)
        S_ACTIVE: dac_data <= pat_out ? lvl_hi_q : lvl_lo_q;
        S_GAP:    dac_data <= lvl_lo_q;
        default:  dac_data <= lvl_idle;
      endcase
    end
  end

endmodule
